// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - debounced push-button event source with press/release/repeat strobes
module key_event_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1,
    parameter int CNT_WIDTH       = 24,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key,
    output logic                   pressed,
    output logic                   press,
    output logic                   release_stb,
    output logic                   repeat_stb,
    output logic [COUNT_WIDTH-1:0] event_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DELAY_C  = CNT_WIDTH'(REPEAT_DELAY);
    localparam logic [CNT_WIDTH-1:0] PERIOD_C = CNT_WIDTH'(REPEAT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    state_t                 state, state_n;
    logic                   key_m, key_s;
    logic [CNT_WIDTH-1:0]   dcnt, dcnt_n;
    logic [CNT_WIDTH-1:0]   rcnt, rcnt_n, rcnt_inc, rlimit;
    logic                   rep_started, rep_started_n;
    logic                   press_n, release_n, repeat_n;

    assign rcnt_inc = rcnt + ONE;
    // rcnt restarts from zero after every repeat, so only the limit changes
    assign rlimit   = rep_started ? PERIOD_C : DELAY_C;
    assign pressed  = (state == HELD) || (state == RELEASE_WAIT);

    always_comb begin
        state_n       = state;
        dcnt_n        = dcnt;
        rcnt_n        = rcnt;
        rep_started_n = rep_started;
        press_n       = 1'b0;
        release_n     = 1'b0;
        repeat_n      = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_n = PRESS_WAIT;
                    dcnt_n  = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_n = IDLE;
                end else if (dcnt == DEB_LAST) begin
                    state_n       = HELD;
                    press_n       = 1'b1;
                    rcnt_n        = '0;
                    rep_started_n = 1'b0;
                end else begin
                    dcnt_n = dcnt + ONE;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_n = RELEASE_WAIT;
                    dcnt_n  = '0;
                end else if (REPEAT_DELAY != 0) begin
                    if (rcnt_inc == rlimit) begin
                        repeat_n      = 1'b1;
                        rcnt_n        = '0;
                        rep_started_n = 1'b1;
                    end else begin
                        rcnt_n = rcnt_inc;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_n = HELD;
                end else if (dcnt == DEB_LAST) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                end else begin
                    dcnt_n = dcnt + ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_m       <= 1'b1;
            key_s       <= 1'b1;
            state       <= IDLE;
            dcnt        <= '0;
            rcnt        <= '0;
            rep_started <= 1'b0;
            press       <= 1'b0;
            release_stb <= 1'b0;
            repeat_stb  <= 1'b0;
            event_count <= '0;
        end else begin
            key_m       <= key;
            key_s       <= key_m;
            state       <= state_n;
            dcnt        <= dcnt_n;
            rcnt        <= rcnt_n;
            rep_started <= rep_started_n;
            press       <= press_n;
            release_stb <= release_n;
            repeat_stb  <= repeat_n;
            if (press_n || repeat_n)
                event_count <= event_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - randomized scoreboard bench for key_event_gen
module tb_key_event_gen;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b1;

    logic       p_a, pr_a, rl_a, rp_a;
    logic [7:0] ec_a;
    logic       p_b, pr_b, rl_b, rp_b;
    logic [7:0] ec_b;

    always #5 clk = ~clk;

    key_event_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
                    .CNT_WIDTH(24), .COUNT_WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .key(key), .pressed(p_a), .press(pr_a),
        .release_stb(rl_a), .repeat_stb(rp_a), .event_count(ec_a));

    key_event_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(1), .REPEAT_PERIOD(1),
                    .CNT_WIDTH(24), .COUNT_WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .key(key), .pressed(p_b), .press(pr_b),
        .release_stb(rl_b), .repeat_stb(rp_b), .event_count(ec_b));

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic [7:0]  cnt;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    int   dly[2] = '{10, 1};
    int   per[2] = '{3, 1};
    logic s1[2], s2[2], acc[2];
    int   run[2], h[2], cnt[2];

    task automatic push_ev(input int i, input logic [1:0] kind);
        ev_t e;
        e.cyc  = 32'(cyc);
        e.kind = kind;
        e.cnt  = 8'(cnt[i]);
        if (i == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    // Reference: a level is accepted after D+1 consecutive synced samples
    // disagree with it; repeats are pure arithmetic on time spent held low.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    s1[i] = 1'b1; s2[i] = 1'b1; acc[i] = 1'b0;
                    run[i] = 0; h[i] = 0; cnt[i] = 0;
                end else begin
                    logic ks, want, was_held;
                    ks       = s2[i];
                    s2[i]    = s1[i];
                    s1[i]    = key;
                    want     = !ks;
                    was_held = acc[i] && (run[i] == 0);
                    run[i]   = (want != acc[i]) ? run[i] + 1 : 0;
                    if (run[i] == D + 1) begin
                        acc[i] = want;
                        run[i] = 0;
                        if (want) begin
                            h[i]   = 0;
                            cnt[i] = (cnt[i] + 1) % 256;
                            push_ev(i, 2'd1);
                        end else begin
                            push_ev(i, 2'd2);
                        end
                    end else if (was_held && want) begin
                        h[i] = h[i] + 1;
                        if (h[i] == dly[i] || (h[i] > dly[i] && (h[i] - dly[i]) % per[i] == 0)) begin
                            cnt[i] = (cnt[i] + 1) % 256;
                            push_ev(i, 2'd3);
                        end
                    end
                end
            end
        end
    end

    task automatic check_dut(input int i, input logic p, input logic pr, input logic rl,
                             input logic rp, input logic [7:0] ec);
        ev_t        e;
        logic [1:0] kind;
        int         n;
        checks++;
        if (p !== acc[i]) begin
            errors++;
            $display("FAIL pressed dut%0d cyc %0d got %0b want %0b", i, cyc, p, acc[i]);
        end
        checks++;
        if (ec !== 8'(cnt[i])) begin
            errors++;
            $display("FAIL event_count dut%0d cyc %0d got %0d want %0d", i, cyc, ec, cnt[i]);
        end
        forever begin
            if (i == 0) begin
                if (qa.size() == 0 || qa[0].cyc >= 32'(cyc)) break;
                e = qa.pop_front();
            end else begin
                if (qb.size() == 0 || qb[0].cyc >= 32'(cyc)) break;
                e = qb.pop_front();
            end
            checks++;
            errors++;
            $display("FAIL missed_strobe dut%0d cyc %0d got none want kind %0d at %0d", i, cyc, e.kind, e.cyc);
        end
        n = int'(pr) + int'(rl) + int'(rp);
        if (n > 1) begin
            checks++;
            errors++;
            $display("FAIL exclusive dut%0d cyc %0d got press %0b release %0b repeat %0b want one", i, cyc, pr, rl, rp);
        end
        if (n > 0) begin
            kind = pr ? 2'd1 : (rl ? 2'd2 : 2'd3);
            checks++;
            if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_strobe dut%0d cyc %0d got kind %0d want none", i, cyc, kind);
            end else begin
                e = (i == 0) ? qa.pop_front() : qb.pop_front();
                if (e.cyc != 32'(cyc) || e.kind != kind || e.cnt != ec) begin
                    errors++;
                    $display("FAIL strobe dut%0d got cyc %0d kind %0d cnt %0d want cyc %0d kind %0d cnt %0d",
                             i, cyc, kind, ec, e.cyc, e.kind, e.cnt);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_dut(0, p_a, pr_a, rl_a, rp_a, ec_a);
            check_dut(1, p_b, pr_b, rl_b, rp_b, ec_b);
        end
    end

    task automatic hold(input logic lvl, input int n);
        key = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 5);
        hold(1'b0, 40);
        hold(1'b1, 20);
        for (int k = 0; k < 5; k++) begin
            hold(1'b0, 2);
            hold(1'b1, 2);
        end
        hold(1'b1, 20);
        hold(1'b0, 20);
        hold(1'b1, 2);
        hold(1'b0, 20);
        hold(1'b1, 20);
        hold(1'b0, 20);
        pulse_rst();
        hold(1'b0, 30);
        hold(1'b1, 20);
        hold(1'b0, 300);
        hold(1'b1, 20);
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 19) == 0) pulse_rst();
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
        end
        hold(1'b1, 20);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL drain dut0 got %0d pending want 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL drain dut1 got %0d pending want 0", qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
